// File: rtl/lcd_frame_capture_pkg.sv
// Shared LCD capture types and frame geometry, also reused by the PPU bench.
package lcd_pkg;

    localparam int unsigned LCD_WIDTH   = 160;
    localparam int unsigned LCD_HEIGHT  = 144;
    localparam int unsigned LCD_BPL     = 40;
    localparam int unsigned PX_PER_BYTE = 4;

    typedef enum logic [1:0] {
        StOff,
        StSync,
        StActive,
        StDrain
    } lcd_state_e;

endpackage

// File: rtl/lcd_frame_capture_if.sv
// Pixel stream from the PPU, framebuffer write port and status flags of the capture block.
interface lcd_frame_capture_if #(
    parameter int unsigned ADR_W = 14
);

    logic             disp_on;
    logic             hsync;
    logic             vsync;
    logic             px_out;
    logic [1:0]       px;
    logic             fb_req;
    logic [ADR_W-1:0] fb_adr;
    logic [7:0]       fb_dat;
    logic             fb_ack;
    logic             fb_bank;
    logic             frame_done;
    logic             err_line;
    logic             err_excess;
    logic             err_ovf;
    logic             err_clr;

    // Master side is the PPU plus the RAM arbiter; slave side is the capture block.
    modport master (
        output disp_on, hsync, vsync, px_out, px, fb_ack, err_clr,
        input  fb_req, fb_adr, fb_dat, fb_bank, frame_done, err_line, err_excess, err_ovf
    );

    modport slave (
        input  disp_on, hsync, vsync, px_out, px, fb_ack, err_clr,
        output fb_req, fb_adr, fb_dat, fb_bank, frame_done, err_line, err_excess, err_ovf
    );

endinterface

// File: rtl/lcd_wr_fifo.sv
// Two-entry write buffer; the head entry is registered and drives the RAM port directly.
module lcd_wr_fifo #(
    parameter int unsigned Width = 22
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    logic [1:0]       vld_q, vld_d;
    logic [Width-1:0] head_q, head_d, tail_q, tail_d;

    always_comb begin
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        if (pop_i && vld_q[0]) begin
            head_d = tail_q;
            vld_d  = {1'b0, vld_q[1]};
        end
        // Pop frees a slot before the push is considered, so push+pop while full is fine.
        if (push_i && !vld_d[1]) begin
            if (!vld_d[0]) begin
                head_d   = data_i;
                vld_d[0] = 1'b1;
            end else begin
                tail_d   = data_i;
                vld_d[1] = 1'b1;
            end
        end
        if (flush_i) begin
            vld_d  = '0;
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign full_o  = vld_q[1];
    assign empty_o = !vld_q[0];
    assign head_o  = head_q;

endmodule

// File: rtl/lcd_frame_capture.sv
// Packs the PPU's 2-bit pixel stream four per byte into a double-banked framebuffer.
module lcd_frame_capture
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH  = LCD_WIDTH,
    parameter int unsigned HEIGHT = LCD_HEIGHT,
    parameter int unsigned BPL    = LCD_BPL,
    parameter int unsigned ADR_W  = 14
) (
    input logic                clk_i,
    input logic                rst_ni,
    lcd_frame_capture_if.slave bus_io
);

    localparam int unsigned OW = ADR_W - 1;
    localparam int unsigned XW = $clog2(WIDTH + 1);
    localparam int unsigned YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] XLim = XW'(WIDTH);
    localparam logic [YW-1:0] YLim = YW'(HEIGHT);
    localparam logic [OW-1:0] Bpl  = OW'(BPL);

    lcd_state_e     state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [OW-1:0]  line_base_q, line_base_d, byte_adr_q, byte_adr_d;
    logic [5:0]     pack_q, pack_d;
    logic           bank_q, bank_d, done_q, done_d;
    logic           err_line_q, err_excess_q, err_ovf_q;
    logic           set_line, set_excess, set_ovf;
    logic           push, pop, flush, fifo_full, fifo_empty;
    logic [ADR_W+7:0] head;

    assign pop     = !fifo_empty && bus_io.fb_ack;
    assign set_ovf = push && fifo_full && !pop;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        line_base_d = line_base_q;
        byte_adr_d  = byte_adr_q;
        pack_d      = pack_q;
        bank_d      = bank_q;
        done_d      = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        set_line    = 1'b0;
        set_excess  = 1'b0;
        if (!bus_io.disp_on) begin
            state_d = StOff;
            flush   = 1'b1;
            pack_d  = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    flush   = 1'b1;
                    pack_d  = '0;
                    state_d = StSync;
                end
                StSync, StActive: begin
                    if (bus_io.vsync) begin
                        // A vsync mid-frame restarts capture in the same bank.
                        set_line    = (state_q == StActive);
                        x_d         = '0;
                        y_d         = '0;
                        line_base_d = '0;
                        byte_adr_d  = '0;
                        pack_d      = '0;
                        state_d     = StActive;
                    end else if (state_q == StActive && bus_io.hsync) begin
                        if (x_q != '0) begin
                            set_line    = (x_q < XLim);
                            pack_d      = '0;
                            line_base_d = line_base_q + Bpl;
                            byte_adr_d  = line_base_q + Bpl;
                            x_d         = '0;
                            if (y_q < YLim) y_d = y_q + 1'b1;
                        end
                    end else if (state_q == StActive && bus_io.px_out) begin
                        if (x_q < XLim && y_q < YLim) begin
                            pack_d = {pack_q[3:0], bus_io.px};
                            x_d    = x_q + 1'b1;
                            if (x_q[1:0] == 2'd3) begin
                                push       = 1'b1;
                                byte_adr_d = byte_adr_q + 1'b1;
                                if (x_q == XLim - 1'b1 && y_q == YLim - 1'b1) state_d = StDrain;
                            end
                        end else begin
                            set_excess = 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        done_d  = 1'b1;
                        bank_d  = !bank_q;
                        state_d = StSync;
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StOff;
            x_q          <= '0;
            y_q          <= '0;
            line_base_q  <= '0;
            byte_adr_q   <= '0;
            pack_q       <= '0;
            bank_q       <= 1'b0;
            done_q       <= 1'b0;
            err_line_q   <= 1'b0;
            err_excess_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_base_q  <= line_base_d;
            byte_adr_q   <= byte_adr_d;
            pack_q       <= pack_d;
            bank_q       <= bank_d;
            done_q       <= done_d;
            // A new error outranks a coincident clear.
            err_line_q   <= set_line   || (err_line_q   && !bus_io.err_clr);
            err_excess_q <= set_excess || (err_excess_q && !bus_io.err_clr);
            err_ovf_q    <= set_ovf    || (err_ovf_q    && !bus_io.err_clr);
        end
    end

    lcd_wr_fifo #(
        .Width (ADR_W + 8)
    ) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .push_i  (push),
        .data_i  ({bank_q, byte_adr_q, pack_q, bus_io.px}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign bus_io.fb_req     = !fifo_empty;
    assign bus_io.fb_adr     = head[ADR_W+7:8];
    assign bus_io.fb_dat     = head[7:0];
    assign bus_io.fb_bank    = bank_q;
    assign bus_io.frame_done = done_q;
    assign bus_io.err_line   = err_line_q;
    assign bus_io.err_excess = err_excess_q;
    assign bus_io.err_ovf    = err_ovf_q;

endmodule

// File: doc/lcd_frame_capture.md
# lcd_frame_capture

Sink for the PPU's display-driver pixel stream (`disp_on`, `hsync`, `vsync`, `px_out`, `px`). The block packs the 2-bit pixels four per byte and writes them to a double-banked framebuffer RAM through a req/ack write port. It tracks line and frame position, raises sticky protocol-error flags, and toggles the bank after each complete frame so scan-out can read the finished bank. It sits between the PPU and the board's framebuffer RAM arbiter.

## Interface
Parameters:
- `WIDTH`, 160: visible pixels per line.
- `HEIGHT`, 144: visible lines per frame.
- `BPL`, 40: bytes per line, WIDTH/4.
- `ADR_W`, 14: framebuffer address width. Bit ADR_W-1 is the bank; the low 13 bits are the byte offset.

Ports:
- `clk`  in  1: single clock, shared with the PPU.
- `reset`  in  1: asynchronous, active-low.
- `disp_on`  in  1: PPU enabled.
- `hsync`  in  1: one-cycle pulse at the start of every line, including vblank lines.
- `vsync`  in  1: one-cycle pulse, coincident with `hsync`, at the start of line 0.
- `px_out`  in  1: `px` is valid on this clk edge; at most one pixel per clk.
- `px`  in  2: pixel colour.
- `fb_req`  out  1: write request.
- `fb_adr`  out  ADR_W: write address. Must be stable while `fb_req` is high.
- `fb_dat`  out  8: write data. Must be stable while `fb_req` is high.
- `fb_ack`  in  1: the write completes on any clk where `fb_req && fb_ack`.
- `fb_bank`  out  1: bank currently being written. Scan-out reads `!fb_bank`.
- `frame_done`  out  1: one-cycle pulse per completed frame.
- `err_line`  out  1: sticky; a line ended with 0 < x < WIDTH.
- `err_excess`  out  1: sticky; a pixel arrived with x==WIDTH or y>=HEIGHT.
- `err_ovf`  out  1: sticky; a packed byte was dropped because the write buffer was full.
- `err_clr`  in  1: clears all sticky errors on the next clk.

## Operation
State machine: `OFF` → `SYNC` → `ACTIVE` → `DRAIN` → `SYNC`.
- `OFF`:
  - Entered on reset, or whenever `disp_on`==0 in any state.
  - Clears the packer and both buffer entries; `fb_req`=0.
  - Exits to `SYNC` when `disp_on`==1.
- `SYNC`:
  - Ignores pixels; they do not raise `err_excess`.
  - On `vsync`: x=0, y=0, line_base=0, byte_adr=0, go to `ACTIVE`.
- `ACTIVE`:
  - Pixel with x<WIDTH and y<HEIGHT: shift into the packer. The first pixel of a group goes to `fb_dat[7:6]`, the fourth to `[1:0]`. x++.
  - On the fourth pixel of a group: push {`fb_bank`, byte_adr} and the byte into the write buffer; byte_adr++.
  - Pixel out of range: drop it, set `err_excess`.
  - `hsync` with x!=0:
    - If x<WIDTH, set `err_line`.
    - Discard any partial packer contents.
    - line_base += BPL; byte_adr = line_base + BPL; x=0; y++.
  - `hsync` with x==0: no change.
  - When the last byte of line HEIGHT-1 has been pushed: go to `DRAIN`.
  - `vsync` in `ACTIVE`: frame restart. Set `err_line`, then act as `vsync` in `SYNC`; the bank does not toggle.
- `DRAIN`:
  - Wait until the write buffer is empty.
  - Then pulse `frame_done`, toggle `fb_bank`, go to `SYNC`.
- Write buffer:
  - Two-entry FIFO. The head drives `fb_req`, `fb_adr`, `fb_dat`.
  - Push while full: drop the new byte, set `err_ovf`.
  - A push and a pop in the same clk are both legal while full (pop frees a slot first).
- Widths: byte_adr and line_base are 13 bits. The maximum offset, 5759, fits; no wrap occurs within a frame.
- `err_clr` coincident with a new error: the error wins.

## Timing
- Reset values: `fb_req`=0, `fb_adr`=0, `fb_dat`=0, `fb_bank`=0, `frame_done`=0, all `err_*`=0, state `OFF`.
- Pixel-to-request latency: `fb_req` rises on the clk after the fourth pixel's `px_out` edge when the buffer was empty.
- `fb_req`, `fb_adr`, `fb_dat` are registered outputs.
- Sustained throughput: one byte per 4 clks. The buffer absorbs up to 7 clks of `fb_ack` stall without loss.
- `frame_done` asserts the clk after the final ack.
- `disp_on` falling: `fb_req`=0 on the next clk; the pending entries are lost and there is no `frame_done`.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately.

## Structure
- Shared package `lcd_pkg`: the state enum (`OFF`, `SYNC`, `ACTIVE`, `DRAIN`) and the constants LCD_WIDTH=160, LCD_HEIGHT=144, LCD_BPL=40, PX_PER_BYTE=4. The PPU bench reuses these.
- One sub-module: `lcd_wr_fifo`, a 2-deep, (ADR_W+8)-bit FIFO with push, full, pop and empty.

## Test plan
- Full frame, `px`=2'b01 every pixel, `fb_ack` tied high → 5760 writes, `fb_dat`=0x55, addresses 0..5759 in bank 0, one `frame_done`, `fb_bank`=1 afterwards, no errors.
- Pixel sequence 0,1,2,3 repeated → every byte is 0x1B; line 1 starts at address 40.
- Hold `fb_ack` low for 7 clks at full pixel rate → no `err_ovf`. Hold it low for 12 clks → `err_ovf`=1, exactly one address missing, total 5759 writes.
- `hsync` after 100 pixels on line 5 → `err_line`=1; line 6's first write goes to address 240.
- 161st pixel in a line → `err_excess`=1, no extra write. `err_clr` → flags return to 0 on the next clk.
- `disp_on` dropped mid-line 70 with a byte pending → `fb_req`=0 on the next clk, no `frame_done`. Re-enable followed by `vsync` → capture restarts at address 0 in the same bank.
